sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the 8x8 buffer.

---
 rtl/sync_fifo_pkg.sv | 29 ++
 rtl/fifo_mem.sv | 30 +++
 rtl/sync_fifo_param.sv | 140 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared sizing helpers and default thresholds for
// sync_fifo_param and its storage sub-module.
//   ptr_w(depth)      : pointer width, at least 1 bit
//   cnt_w(depth)      : occupancy width, able to hold 0..depth
//   default_af(depth) : default almost-full threshold (depth-1)
//   thresh_ok(...)    : legal range check for both thresholds
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_AE_THRESH = 1;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned default_af(input int unsigned depth);
    return depth - 1;
  endfunction

  function automatic bit thresh_ok(input int unsigned depth,
                                   input int unsigned af,
                                   input int unsigned ae);
    return (af >= 1) && (af <= depth) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage array, WIDTH x DEPTH.
// Synchronous write, asynchronous (combinational) read, no reset.
//   clk_i   : clock, rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, mem[raddr_i]
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds and overflow/underflow pulses.
//   clk, rst (async, active-high)
//   wr_en, wr_data            : write request / data
//   rd_en                     : read request (pop/ack in FWFT mode)
//   rd_data, rd_valid         : read data / valid
//   full, empty, almost_full, almost_empty, count : decodes of occupancy
//   overflow, underflow       : 1-cycle pulses for rejected requests
// Optional feature: define SYNC_FIFO_FWFT_EN for first-word-fall-through,
// otherwise reads are registered with 1-cycle latency.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = default_af(DEPTH),
  parameter int unsigned AE_THRESH = DEFAULT_AE_THRESH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

  if (WIDTH < 1 || DEPTH < 2) begin : g_bad_size
    $error("sync_fifo_param: WIDTH must be >= 1 and DEPTH >= 2");
  end
  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_param: AF_THRESH must be 1..DEPTH, AE_THRESH 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Flags decode the registered count only.
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = wr_en && full;
    unf_d    = rd_en && empty;
    // Explicit wrap so non-power-of-2 depths work.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always presented; rd_en only pops it.
  assign rd_data  = mem_rdata;
  assign rd_valid = !empty;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_acc ? mem_rdata : rd_data_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives two FIFO instances (DEPTH=8 defaults, and
// DEPTH=5 with AF_THRESH=4/AE_THRESH=1) in lockstep and compares every
// output against a queue-based reference model after each clock edge.
// Honours SYNC_FIFO_FWFT_EN for the read-side expectations.
module tb_sync_fifo_param;

  typedef logic [7:0] byte_q_t [$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       wr   [2];
  logic [7:0] din  [2];
  logic       rd   [2];

  logic [7:0] rdata_a, rdata_b;
  logic       rvalid_a, rvalid_b, full_a, full_b, empty_a, empty_b;
  logic       af_a, af_b, ae_a, ae_b, ovf_a, ovf_b, unf_a, unf_b;
  logic [3:0] count_a;
  logic [2:0] count_b;

  logic [7:0] g_rdata [2];
  logic       g_rvalid[2], g_full[2], g_empty[2], g_af[2], g_ae[2], g_ovf[2], g_unf[2];
  logic [3:0] g_cnt   [2];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state
  byte_q_t     mq     [2];
  logic [7:0]  m_rdd  [2];
  logic        m_rdv  [2];
  logic        m_ovf  [2];
  logic        m_unf  [2];
  int unsigned m_depth[2] = '{8, 5};
  int unsigned m_af   [2] = '{7, 4};
  int unsigned m_ae   [2] = '{1, 1};

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH (8),
    .DEPTH (8)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr[0]),
    .wr_data      (din[0]),
    .rd_en        (rd[0]),
    .rd_data      (rdata_a),
    .rd_valid     (rvalid_a),
    .full         (full_a),
    .empty        (empty_a),
    .almost_full  (af_a),
    .almost_empty (ae_a),
    .count        (count_a),
    .overflow     (ovf_a),
    .underflow    (unf_a)
  );

  sync_fifo_param #(
    .WIDTH     (8),
    .DEPTH     (5),
    .AF_THRESH (4),
    .AE_THRESH (1)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr[1]),
    .wr_data      (din[1]),
    .rd_en        (rd[1]),
    .rd_data      (rdata_b),
    .rd_valid     (rvalid_b),
    .full         (full_b),
    .empty        (empty_b),
    .almost_full  (af_b),
    .almost_empty (ae_b),
    .count        (count_b),
    .overflow     (ovf_b),
    .underflow    (unf_b)
  );

  always_comb begin
    g_rdata[0] = rdata_a;  g_rdata[1] = rdata_b;
    g_rvalid[0] = rvalid_a; g_rvalid[1] = rvalid_b;
    g_full[0] = full_a;    g_full[1] = full_b;
    g_empty[0] = empty_a;  g_empty[1] = empty_b;
    g_af[0] = af_a;        g_af[1] = af_b;
    g_ae[0] = ae_a;        g_ae[1] = ae_b;
    g_ovf[0] = ovf_a;      g_ovf[1] = ovf_b;
    g_unf[0] = unf_a;      g_unf[1] = unf_b;
    g_cnt[0] = count_a;    g_cnt[1] = {1'b0, count_b};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] b2w(input logic b);
    return {31'd0, b};
  endfunction

  task automatic model_edge(input int i);
    int unsigned n = mq[i].size();
    logic m_full  = (n == m_depth[i]);
    logic m_empty = (n == 0);
    m_ovf[i] = wr[i] && m_full;
    m_unf[i] = rd[i] && m_empty;
    if (rd[i] && !m_empty) begin
      m_rdd[i] = mq[i].pop_front();
      m_rdv[i] = 1'b1;
    end else begin
      m_rdv[i] = 1'b0;
    end
    if (wr[i] && !m_full) mq[i].push_back(din[i]);
  endtask

  task automatic check_dut(input int i);
    int unsigned n = mq[i].size();
    check_eq($sformatf("count%0d", i), {28'd0, g_cnt[i]}, n);
    check_eq($sformatf("full%0d", i), b2w(g_full[i]), b2w(n == m_depth[i]));
    check_eq($sformatf("empty%0d", i), b2w(g_empty[i]), b2w(n == 0));
    check_eq($sformatf("almost_full%0d", i), b2w(g_af[i]), b2w(n >= m_af[i]));
    check_eq($sformatf("almost_empty%0d", i), b2w(g_ae[i]), b2w(n <= m_ae[i]));
    check_eq($sformatf("overflow%0d", i), b2w(g_ovf[i]), b2w(m_ovf[i]));
    check_eq($sformatf("underflow%0d", i), b2w(g_unf[i]), b2w(m_unf[i]));
`ifdef SYNC_FIFO_FWFT_EN
    check_eq($sformatf("rd_valid%0d", i), b2w(g_rvalid[i]), b2w(n != 0));
    if (n != 0) check_eq($sformatf("rd_data%0d", i), {24'd0, g_rdata[i]}, {24'd0, mq[i][0]});
`else
    check_eq($sformatf("rd_valid%0d", i), b2w(g_rvalid[i]), b2w(m_rdv[i]));
    check_eq($sformatf("rd_data%0d", i), {24'd0, g_rdata[i]}, {24'd0, m_rdd[i]});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) check_dut(i);
  endtask

  task automatic drive(input int i, input logic w, input logic [7:0] d, input logic r);
    wr[i] = w; din[i] = d; rd[i] = r;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 8'h00, 1'b0);
  endtask

  // rst asserted between edges: outputs must clear without any clock.
  task automatic reset_check(input string tag);
    rst = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_count%0d", tag, i), {28'd0, g_cnt[i]}, 32'd0);
      check_eq($sformatf("%s_empty%0d", tag, i), b2w(g_empty[i]), 32'd1);
      check_eq($sformatf("%s_full%0d", tag, i), b2w(g_full[i]), 32'd0);
      check_eq($sformatf("%s_ae%0d", tag, i), b2w(g_ae[i]), 32'd1);
      check_eq($sformatf("%s_af%0d", tag, i), b2w(g_af[i]), 32'd0);
      check_eq($sformatf("%s_rd_valid%0d", tag, i), b2w(g_rvalid[i]), 32'd0);
      check_eq($sformatf("%s_ovf%0d", tag, i), b2w(g_ovf[i]), 32'd0);
      check_eq($sformatf("%s_unf%0d", tag, i), b2w(g_unf[i]), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      check_eq($sformatf("%s_rd_data%0d", tag, i), {24'd0, g_rdata[i]}, 32'd0);
`endif
      mq[i].delete();
      m_rdd[i] = 8'h00;
      m_rdv[i] = 1'b0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end
    idle_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic random_traffic(input int cycles, input int unsigned wr_pct, input int unsigned rd_pct);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 2; i++)
        drive(i, $urandom_range(99, 0) < wr_pct, 8'($urandom_range(255, 0)),
              $urandom_range(99, 0) < rd_pct);
      step();
    end
  endtask

  initial begin
    idle_all();
    #3;
    reset_check("por");

    // Fill DEPTH=8, overflow on 9th write, drain in order.
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1'b1, 8'(k), 1'b0);
      step();
    end
    drive(0, 1'b1, 8'hFF, 1'b0);
    step();
    idle_all();
    step();
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b0, 8'h00, 1'b1);
      step();
    end
    idle_all();
    step();

    // Read while empty.
    drive(0, 1'b0, 8'h00, 1'b1);
    step();
    idle_all();
    step();

    // Steady simultaneous traffic at count=3, pointers wrap.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 8'h10 + 8'(k), 1'b0);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(0, 1'b1, 8'h40 + 8'(k), 1'b1);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b0, 8'h00, 1'b1);
      step();
    end
    idle_all();

    // DEPTH=5 threshold sweep 0..5, overflow, then drain past empty.
    for (int k = 0; k < 6; k++) begin
      drive(1, 1'b1, 8'hA0 + 8'(k), 1'b0);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      drive(1, 1'b0, 8'h00, 1'b1);
      step();
    end
    idle_all();
    step();

    // Both requests at full (DEPTH=5) and at empty.
    for (int k = 0; k < 5; k++) begin
      drive(1, 1'b1, 8'hC0 + 8'(k), 1'b0);
      step();
    end
    drive(1, 1'b1, 8'hEE, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1'b0, 8'h00, 1'b1);
      step();
    end
    drive(1, 1'b1, 8'h5A, 1'b1);
    step();
    idle_all();
    step();

    random_traffic(300, 60, 40);
    random_traffic(300, 40, 60);
    random_traffic(200, 80, 20);
    reset_check("mid");
    random_traffic(300, 50, 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
